// File: rtl/key_control_if.sv
// Byte-in / action-out bundle between the PS/2 receiver, key_control and movement logic.
interface key_control_if;
  logic [7:0] keycode;
  logic       keycode_valid;
  logic       left;
  logic       right;
  logic       jump;
  logic       start_game;

  modport master (
    output keycode, keycode_valid,
    input  left, right, jump, start_game
  );

  modport slave (
    input  keycode, keycode_valid,
    output left, right, jump, start_game
  );
endinterface

// File: rtl/key_control.sv
// PS/2 set-2 scan-code decoder producing left/right/jump levels and a sticky start flag.
// Optional macro KEY_WASD_EN adds A/D/W as alternate left/right/jump keys.
module key_control #(
  parameter logic [20:0] PREFIX_TIMEOUT = 21'd1_000_000
) (
  input  logic          clk,
  input  logic          rst,
  key_control_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BREAK,
    ST_EXT_BREAK
  } state_t;

  localparam logic [7:0] KC_EXT   = 8'hE0;
  localparam logic [7:0] KC_BREAK = 8'hF0;
  localparam logic [7:0] KC_LEFT  = 8'h6B;
  localparam logic [7:0] KC_RIGHT = 8'h74;
  localparam logic [7:0] KC_SPACE = 8'h29;
  localparam logic [7:0] KC_ENTER = 8'h5A;

  state_t      r_state;
  state_t      w_state_next;
  logic [20:0] r_cnt;
  logic [21:0] w_cnt_inc;
  logic        r_lar_held, r_rar_held, r_sp_held;
  logic        w_lar_next, w_rar_next, w_sp_next;
  logic        r_last_right;
  logic        w_last_right_next;
  logic        r_start;
  logic        w_start_next;
  logic        r_left, r_right, r_jump;
  logic        w_left_act, w_right_act, w_jump_act;
  logic        w_prefix, w_done, w_ext, w_make;
  logic        w_left_make, w_right_make;
  logic        w_left_any, w_right_any, w_jump_any;

`ifdef KEY_WASD_EN
  localparam logic [7:0] KC_A = 8'h1C;
  localparam logic [7:0] KC_D = 8'h23;
  localparam logic [7:0] KC_W = 8'h1D;
  logic r_a_held, r_d_held, r_w_held;
  logic w_a_next, w_d_next, w_w_next;
`endif

  assign w_cnt_inc = {1'b0, r_cnt} + 22'd1;

  // A byte completes a code unless it is a prefix that the current state can still accept.
  always_comb begin
    w_prefix = ((r_state == ST_IDLE) && ((bus.keycode == KC_EXT) || (bus.keycode == KC_BREAK))) ||
               ((r_state == ST_EXT) && (bus.keycode == KC_BREAK));
    w_done   = bus.keycode_valid && !w_prefix;
    w_ext    = (r_state == ST_EXT) || (r_state == ST_EXT_BREAK);
    w_make   = (r_state == ST_IDLE) || (r_state == ST_EXT);
  end

  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (bus.keycode == KC_EXT)
          w_state_next = ST_EXT;
        else if (bus.keycode == KC_BREAK)
          w_state_next = ST_BREAK;
      end
      ST_EXT: begin
        if (bus.keycode == KC_BREAK)
          w_state_next = ST_EXT_BREAK;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_lar_next = r_lar_held;
    w_rar_next = r_rar_held;
    w_sp_next  = r_sp_held;
    if (w_done && w_ext && (bus.keycode == KC_LEFT))
      w_lar_next = w_make;
    if (w_done && w_ext && (bus.keycode == KC_RIGHT))
      w_rar_next = w_make;
    if (w_done && !w_ext && (bus.keycode == KC_SPACE))
      w_sp_next = w_make;
    w_start_next = r_start || (w_done && w_make && !w_ext && (bus.keycode == KC_ENTER));
    w_left_make  = w_done && w_make && w_ext && (bus.keycode == KC_LEFT);
    w_right_make = w_done && w_make && w_ext && (bus.keycode == KC_RIGHT);
`ifdef KEY_WASD_EN
    w_a_next = r_a_held;
    w_d_next = r_d_held;
    w_w_next = r_w_held;
    if (w_done && !w_ext && (bus.keycode == KC_A))
      w_a_next = w_make;
    if (w_done && !w_ext && (bus.keycode == KC_D))
      w_d_next = w_make;
    if (w_done && !w_ext && (bus.keycode == KC_W))
      w_w_next = w_make;
    w_left_make  = w_left_make  || (w_done && w_make && !w_ext && (bus.keycode == KC_A));
    w_right_make = w_right_make || (w_done && w_make && !w_ext && (bus.keycode == KC_D));
    w_left_any   = w_lar_next || w_a_next;
    w_right_any  = w_rar_next || w_d_next;
    w_jump_any   = w_sp_next  || w_w_next;
`else
    w_left_any   = w_lar_next;
    w_right_any  = w_rar_next;
    w_jump_any   = w_sp_next;
`endif
    w_last_right_next = r_last_right;
    if (w_left_make)
      w_last_right_next = 1'b0;
    else if (w_right_make)
      w_last_right_next = 1'b1;
    // With both directions held, only the most recently pressed one is driven.
    w_left_act  = w_start_next && w_left_any  && (!w_right_any || !w_last_right_next);
    w_right_act = w_start_next && w_right_any && (!w_left_any  ||  w_last_right_next);
    w_jump_act  = w_start_next && w_jump_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_lar_held   <= 1'b0;
      r_rar_held   <= 1'b0;
      r_sp_held    <= 1'b0;
      r_last_right <= 1'b0;
      r_start      <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_jump       <= 1'b0;
`ifdef KEY_WASD_EN
      r_a_held     <= 1'b0;
      r_d_held     <= 1'b0;
      r_w_held     <= 1'b0;
`endif
    end else begin
      if (bus.keycode_valid) begin
        r_state <= w_state_next;
        r_cnt   <= '0;
      end else if (r_state != ST_IDLE) begin
        // A stale prefix is dropped once the gap reaches the timeout.
        if (w_cnt_inc >= {1'b0, PREFIX_TIMEOUT}) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_inc[20:0];
        end
      end
      r_lar_held   <= w_lar_next;
      r_rar_held   <= w_rar_next;
      r_sp_held    <= w_sp_next;
      r_last_right <= w_last_right_next;
      r_start      <= w_start_next;
      r_left       <= w_left_act;
      r_right      <= w_right_act;
      r_jump       <= w_jump_act;
`ifdef KEY_WASD_EN
      r_a_held     <= w_a_next;
      r_d_held     <= w_d_next;
      r_w_held     <= w_w_next;
`endif
    end
  end

  assign bus.left       = r_left;
  assign bus.right      = r_right;
  assign bus.jump       = r_jump;
  assign bus.start_game = r_start;

endmodule

// File: tb/tb_key_control.sv
// Scoreboarded bench for key_control: directed scan-code scenarios plus random byte streams
// checked against a key-state reference model.
module tb_key_control;

  localparam int PT = 8;

  logic clk;
  logic rst;
  logic chk_req;
  key_control_if bus();

  key_control #(.PREFIX_TIMEOUT(21'd8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    string      name;
    logic [7:0] kc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  // Reference model: which physical keys are held, when each direction was last pressed,
  // and which prefixes are pending.
  bit          m_la, m_ra, m_sp, m_a, m_d, m_w;
  bit          m_started;
  bit          m_ext_p, m_brk_p;
  int unsigned m_tick;
  int unsigned m_t_left, m_t_right;

  function automatic void model_reset();
    m_la = 0; m_ra = 0; m_sp = 0; m_a = 0; m_d = 0; m_w = 0;
    m_started = 0; m_ext_p = 0; m_brk_p = 0;
    m_t_left = 0; m_t_right = 0;
  endfunction

  function automatic void model_code(input logic [7:0] b, input bit ext, input bit brk);
    bit mk;
    mk = !brk;
    if (ext && b == 8'h6B) begin m_la = mk; if (mk) begin m_tick++; m_t_left = m_tick; end end
    if (ext && b == 8'h74) begin m_ra = mk; if (mk) begin m_tick++; m_t_right = m_tick; end end
    if (!ext && b == 8'h29) m_sp = mk;
    if (!ext && b == 8'h5A && mk) m_started = 1;
`ifdef KEY_WASD_EN
    if (!ext && b == 8'h1C) begin m_a = mk; if (mk) begin m_tick++; m_t_left = m_tick; end end
    if (!ext && b == 8'h23) begin m_d = mk; if (mk) begin m_tick++; m_t_right = m_tick; end end
    if (!ext && b == 8'h1D) m_w = mk;
`endif
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int gap);
    if ((m_ext_p || m_brk_p) && gap >= PT) begin
      m_ext_p = 0;
      m_brk_p = 0;
    end
    if (b == 8'hE0 && !m_ext_p && !m_brk_p)
      m_ext_p = 1;
    else if (b == 8'hF0 && !m_brk_p)
      m_brk_p = 1;
    else begin
      model_code(b, m_ext_p, m_brk_p);
      m_ext_p = 0;
      m_brk_p = 0;
    end
  endfunction

  function automatic logic [3:0] model_out();
    bit lh, rh, jh, l, r;
    lh = m_la || m_a;
    rh = m_ra || m_d;
    jh = m_sp || m_w;
    l  = m_started && lh && (!rh || m_t_left > m_t_right);
    r  = m_started && rh && (!lh || m_t_right > m_t_left);
    return {l, r, m_started && jh, m_started};
  endfunction

  task automatic send(input logic [7:0] b, input int gap);
    exp_t e;
    repeat (gap) @(negedge clk);
    model_byte(b, gap);
    e.v = model_out();
    e.name = "byte";
    e.kc = b;
    exp_q.push_back(e);
    bus.keycode = b;
    bus.keycode_valid = 1'b1;
    @(negedge clk);
    bus.keycode_valid = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    chk_req = 1'b1;
    model_reset();
    e.v = 4'b0000;
    e.name = nm;
    e.kc = 8'h00;
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b0;
    chk_req = 1'b0;
  endtask

  // Monitor: a strobe (byte or reset probe) at a rising edge produces a response visible
  // by the following falling edge.
  initial begin
    exp_t       e;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      if (bus.keycode_valid || chk_req) begin
        @(negedge clk);
        got = {bus.left, bus.right, bus.jump, bus.start_game};
        total++;
        txn++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_response got=%b required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e.v) begin
            bad++;
            $display("FAIL %s kc=%h got(l,r,j,s)=%b required=%b", e.name, e.kc, got, e.v);
          end else begin
            $display("txn %0d %s kc=%h out(l,r,j,s)=%b", txn, e.name, e.kc, got);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] pool[12];
    int gap, sel, n;
    pool = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h29, 8'h5A, 8'h1C, 8'h23, 8'h1D, 8'h12, 8'hE0, 8'hF0};
    m_tick = 0;
    model_reset();
    rst = 1'b1;
    chk_req = 1'b0;
    bus.keycode = 8'h00;
    bus.keycode_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    do_reset("reset");

    // Enter then extended left press and release.
    send(8'h5A, 1); send(8'hE0, 0); send(8'h6B, 0);
    send(8'hE0, 2); send(8'hF0, 0); send(8'h6B, 0);
    do_reset("reset2");

    // Direction held before start is gated until Enter.
    send(8'hE0, 0); send(8'h6B, 0); send(8'h5A, 3);
    // Left then right held: right wins; releasing right restores left.
    send(8'hE0, 0); send(8'h74, 0);
    send(8'hE0, 1); send(8'hF0, 0); send(8'h74, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0);

    // Prefix timeout: gap just under the limit keeps the prefix, at the limit drops it.
    send(8'hE0, 0); send(8'h6B, PT - 1);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, PT - 1);
    send(8'hE0, 0); send(8'h6B, PT);
    send(8'hE0, 0); send(8'hF0, PT); send(8'h6B, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0);

    // Typematic space then release; prefix bytes as break-code bytes.
    for (int i = 0; i < 6; i++) send(8'h29, 1);
    send(8'hF0, 0); send(8'h29, 0);
    send(8'hF0, 0); send(8'hE0, 0); send(8'h29, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'hF0, 0);
    send(8'h6B, 0); send(8'h74, 0); send(8'hE0, 0); send(8'h29, 0);

    // Reset in the middle of an extended break discards everything.
    send(8'hE0, 0); send(8'hF0, 0);
    do_reset("reset_mid");
    send(8'h6B, 0);

    // Alternate left key overlapping the arrow key.
    send(8'h5A, 0); send(8'h1C, 0); send(8'hE0, 0); send(8'h6B, 0);
    send(8'hF0, 0); send(8'h1C, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h6B, 0);
    send(8'h1C, 0); send(8'h23, 2); send(8'h1D, 0);
    send(8'hF0, 0); send(8'h23, 0);

    // Random streams.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 11);
      n = $urandom_range(0, 9);
      if (n < 6) gap = $urandom_range(0, 2);
      else if (n < 9) gap = PT - 1 + $urandom_range(0, 2);
      else gap = $urandom_range(3, 20);
      if ($urandom_range(0, 79) == 0) do_reset("reset_rand");
      send(pool[sel], gap);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/key_control.md
KEY_CONTROL -- requirements
Module: key_control

Interface
REQ-001 SHALL have parameter PREFIX_TIMEOUT, default 21'd1_000_000: maximum cycles allowed between a prefix byte (E0/F0) and the following byte.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port keycode  input  8  PS/2 set-2 byte from the receiver.
REQ-005 SHALL have port keycode_valid  input  1  one-cycle strobe; keycode is valid in that cycle only.
REQ-006 SHALL have port left  output  1  move-left request level, consumed by movement.
REQ-007 SHALL have port right  output  1  move-right request level.
REQ-008 SHALL have port jump  output  1  jump request level.
REQ-009 SHALL have port start_game  output  1  sticky game-start flag.

Function
REQ-010 SHALL decode with FSM states ST_IDLE, ST_EXT (E0 seen), ST_BREAK (F0 seen), ST_EXT_BREAK (E0 F0 seen); transitions occur only in cycles with keycode_valid=1, except timeout.
REQ-011 SHALL transition ST_IDLE: E0->ST_EXT; F0->ST_BREAK; any other byte stays in ST_IDLE and is treated as a make code.
REQ-012 SHALL transition ST_EXT: F0->ST_EXT_BREAK; any other byte is an extended make code, then ->ST_IDLE.
REQ-013 SHALL treat any byte in ST_BREAK or ST_EXT_BREAK as a break code of that class, then ->ST_IDLE.
REQ-014 SHALL keep held flags: left_held (extended 6B), right_held (extended 74), jump_held (non-extended 29, space); make sets, break clears; repeated make (typematic) is idempotent.
REQ-015 SHALL set start_game on non-extended make 5A (Enter); cleared only by rst.
REQ-016 SHALL ignore unmapped codes (no flag change); 6B/74 without E0, or 29 with E0, are unmapped.
REQ-017 SHALL resolve left_held and right_held both set by driving only the direction whose make arrived most recently (last-press-wins register); on release of that key, the other held direction becomes active in the next cycle.
REQ-018 SHALL drive left/right/jump as the resolved held flags gated by start_game; all are 0 while start_game=0.
REQ-019 SHALL update outputs registered, one clk after the keycode_valid cycle of the final byte of a sequence.
REQ-020 SHALL count cycles in any non-IDLE state with a saturating counter; on reaching PREFIX_TIMEOUT with no valid byte, return to ST_IDLE, discarding the prefix, with no flag change.
REQ-021 SHALL reset the timeout counter on every keycode_valid and on entry to ST_IDLE.
REQ-022 SHALL treat E0 or F0 arriving while in ST_BREAK/ST_EXT_BREAK as the break-code byte, then ->ST_IDLE.

Reset
REQ-023 SHALL on rst=1 set state=ST_IDLE, all held flags=0, last-press register=left, timeout counter=0, left=right=jump=start_game=0 in the following cycle; rst mid-sequence discards the sequence.

Configuration
REQ-024 SHALL, when macro KEY_WASD_EN is defined, additionally map non-extended 1C (A) to left, 23 (D) to right, 1D (W) to jump; each action is held while either of its keys is held.
REQ-025 SHALL, without KEY_WASD_EN, treat 1C/23/1D as unmapped.

Verification
REQ-026 SHALL cover: 5A, then E0 6B -> start_game=1; left=1 one cycle after the 6B strobe; then E0 F0 6B -> left=0.
REQ-027 SHALL cover: E0 6B without prior 5A -> left=0; then 5A -> left=1 the cycle after the 5A strobe.
REQ-028 SHALL cover: after start, E0 6B, E0 74 -> right=1, left=0; E0 F0 74 -> left=1, right=0.
REQ-029 SHALL cover: E0 then PREFIX_TIMEOUT idle cycles, then 6B -> left unchanged (6B non-extended, unmapped); state ST_IDLE.
REQ-030 SHALL cover: 29 held with 29 repeated 5 times -> jump=1 throughout; F0 29 -> jump=0; rst mid E0 F0 -> all outputs 0, start_game=0.
REQ-031 SHALL cover, with KEY_WASD_EN: after start, 1C and E0 6B, then F0 1C -> left stays 1; without KEY_WASD_EN, 1C alone -> left=0.
